i2c_reg_seq: RTL and testbench

I2C_REG_SEQ -- requirements
Module: i2c_reg_seq

---
 rtl/i2c_reg_seq_if.sv | 30 +++
 rtl/i2c_reg_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_i2c_reg_seq.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_reg_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2c_reg_seq_if
//  Brief    : Command bus between the register sequencer and a byte-level
//             I2C master engine.
//  Revision : 1.0
// ============================================================================
interface i2c_reg_seq_if;
  logic [2:0] m_cmd;        // START=000 WR=001 RD=010 STOP=011 RESTART=100
  logic [7:0] m_din;        // byte to send; for RD bit0 is the master ACK bit
  logic       m_wr;         // one-cycle command strobe
  logic       m_ready;      // engine can accept a command
  logic       m_done_tick;  // engine finished a WR/RD byte
  logic       m_ack;        // ACK bit of the last byte (0 = ACK)
  logic [7:0] m_dout;       // byte received by the engine

  // Sequencer side: issues commands, observes engine status.
  modport master (
    output m_cmd, m_din, m_wr,
    input  m_ready, m_done_tick, m_ack, m_dout
  );

  // Engine side: consumes commands, reports status.
  modport slave (
    input  m_cmd, m_din, m_wr,
    output m_ready, m_done_tick, m_ack, m_dout
  );
endinterface
`default_nettype wire

// File: rtl/i2c_reg_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : i2c_reg_seq
//  Brief    : Sequences one I2C register write or read as a list of byte-level
//             commands to an I2C master engine (START/WR/RESTART/RD/STOP).
//  Revision : 1.0
// ============================================================================
module i2c_reg_seq #(
  parameter bit STOP_ON_NACK = 1'b1   // 1: jump to STOP on slave NACK
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        start,
  input  wire logic        rw,
  input  wire logic [6:0]  dev_addr,
  input  wire logic [7:0]  reg_addr,
  input  wire logic [7:0]  wdata,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rdata,
  output logic             nack_err,
  i2c_reg_seq_if.master    m_bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ISSUE  = 3'd1;
  localparam logic [2:0] ST_SEND   = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  localparam logic [2:0] CMD_START   = 3'b000;
  localparam logic [2:0] CMD_WR      = 3'b001;
  localparam logic [2:0] CMD_RD      = 3'b010;
  localparam logic [2:0] CMD_STOP    = 3'b011;
  localparam logic [2:0] CMD_RESTART = 3'b100;

  // Index of the STOP step in each sequence; also the highest legal step.
  localparam logic [2:0] STEP_STOP_WR = 3'd4;
  localparam logic [2:0] STEP_STOP_RD = 3'd6;

  logic [2:0] state_q, state_d;
  logic [2:0] step_q, step_d;
  logic       rw_q, rw_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] wdata_q, wdata_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] rdata_q, rdata_d;
  logic       nack_q, nack_d;
  logic [2:0] m_cmd_q, m_cmd_d;
  logic [7:0] m_din_q, m_din_d;
  logic       m_wr_q, m_wr_d;
  logic       tick_seen_q, tick_seen_d;
  logic       abort_q, abort_d;

  // Command and data byte for a given step. Any step outside the sequence
  // decodes to STOP so a corrupted counter can only end the transaction.
  function automatic logic [10:0] step_decode(
    input logic       is_rd,
    input logic [2:0] step,
    input logic [6:0] dev,
    input logic [7:0] ra,
    input logic [7:0] wd
  );
    logic [10:0] r;
    r = {CMD_STOP, 8'h00};
    if (!is_rd) begin
      case (step)
        3'd0:    r = {CMD_START, 8'h00};
        3'd1:    r = {CMD_WR, dev, 1'b0};
        3'd2:    r = {CMD_WR, ra};
        3'd3:    r = {CMD_WR, wd};
        default: r = {CMD_STOP, 8'h00};
      endcase
    end else begin
      case (step)
        3'd0:    r = {CMD_START, 8'h00};
        3'd1:    r = {CMD_WR, dev, 1'b0};
        3'd2:    r = {CMD_WR, ra};
        3'd3:    r = {CMD_RESTART, 8'h00};
        3'd4:    r = {CMD_WR, dev, 1'b1};
        3'd5:    r = {CMD_RD, 8'h01};   // single byte read, master NACKs it
        default: r = {CMD_STOP, 8'h00};
      endcase
    end
    return r;
  endfunction

  // WAIT qualifiers: byte commands need a done tick (now or earlier) plus
  // m_ready; bus-condition commands need only m_ready.
  logic       is_byte;
  logic       first_tick;
  logic       advance;
  logic       abort_now;
  logic [2:0] stop_step;

  assign is_byte    = (m_cmd_q == CMD_WR) || (m_cmd_q == CMD_RD);
  assign first_tick = is_byte && m_bus.m_done_tick && !tick_seen_q;
  assign advance    = m_bus.m_ready && (!is_byte || tick_seen_q || m_bus.m_done_tick);
  assign abort_now  = STOP_ON_NACK && first_tick && (m_cmd_q == CMD_WR) && m_bus.m_ack;
  assign stop_step  = rw_q ? STEP_STOP_RD : STEP_STOP_WR;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      step_q      <= 3'd0;
      rw_q        <= 1'b0;
      dev_q       <= 7'd0;
      reg_q       <= 8'd0;
      wdata_q     <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= 8'd0;
      nack_q      <= 1'b0;
      m_cmd_q     <= CMD_START;
      m_din_q     <= 8'd0;
      m_wr_q      <= 1'b0;
      tick_seen_q <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      rw_q        <= rw_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      nack_q      <= nack_d;
      m_cmd_q     <= m_cmd_d;
      m_din_q     <= m_din_d;
      m_wr_q      <= m_wr_d;
      tick_seen_q <= tick_seen_d;
      abort_q     <= abort_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_ISSUE;
      ST_ISSUE:  if (m_bus.m_ready) state_d = ST_SEND;
      ST_SEND:   state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_WAIT;
      ST_WAIT:   if (advance) state_d = (m_cmd_q == CMD_STOP) ? ST_FINISH : ST_ISSUE;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath and output register updates for each state.
  always_comb begin
    step_d      = step_q;
    rw_d        = rw_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
    nack_d      = nack_q;
    m_cmd_d     = m_cmd_q;
    m_din_d     = m_din_q;
    m_wr_d      = 1'b0;
    tick_seen_d = tick_seen_q;
    abort_d     = abort_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rw_d    = rw;
          dev_d   = dev_addr;
          reg_d   = reg_addr;
          wdata_d = wdata;
          nack_d  = 1'b0;
          step_d  = 3'd0;
          abort_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (m_bus.m_ready) begin
          {m_cmd_d, m_din_d} = step_decode(rw_q, step_q, dev_q, reg_q, wdata_q);
          m_wr_d             = 1'b1;
        end
      end
      ST_SETTLE: begin
        // Ticks from an earlier byte must not satisfy this one.
        tick_seen_d = 1'b0;
      end
      ST_WAIT: begin
        if (first_tick) begin
          tick_seen_d = 1'b1;
          if (m_cmd_q == CMD_WR && m_bus.m_ack) begin
            nack_d = 1'b1;
            if (STOP_ON_NACK) abort_d = 1'b1;
          end
          if (m_cmd_q == CMD_RD) rdata_d = m_bus.m_dout;
        end
        if (advance) begin
          if (m_cmd_q == CMD_STOP)
            done_d = 1'b1;
          else if (abort_q || abort_now || step_q >= stop_step)
            step_d = stop_step;
          else
            step_d = step_q + 3'd1;
        end
      end
      ST_FINISH: begin
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign nack_err    = nack_q;
  assign m_bus.m_cmd = m_cmd_q;
  assign m_bus.m_din = m_din_q;
  assign m_bus.m_wr  = m_wr_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_reg_seq
//  Brief    : Scoreboard bench for i2c_reg_seq with a behavioural I2C engine.
//  Revision : 1.0
// ============================================================================
module tb_i2c_reg_seq;

  localparam logic [2:0] C_START   = 3'b000;
  localparam logic [2:0] C_WR      = 3'b001;
  localparam logic [2:0] C_RD      = 3'b010;
  localparam logic [2:0] C_STOP    = 3'b011;
  localparam logic [2:0] C_RESTART = 3'b100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       rw;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       nack_err;

  i2c_reg_seq_if bus();

  i2c_reg_seq #(.STOP_ON_NACK(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rw       (rw),
    .dev_addr (dev_addr),
    .reg_addr (reg_addr),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .nack_err (nack_err),
    .m_bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [2:0] cmd; logic [7:0] din; } cmd_t;
  typedef struct packed { logic nack; logic [7:0] rdata; } done_t;

  cmd_t  cmd_q[$];
  done_t done_q[$];

  int         checks;
  int         errors;
  int         wr_cnt;
  int         lat;
  int         spur_cnt;
  logic       nack_en;
  logic [7:0] nack_din;
  logic [7:0] slave_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_cmd(input logic [2:0] c, input logic [7:0] d);
    cmd_t e;
    e.cmd = c;
    e.din = d;
    cmd_q.push_back(e);
  endtask

  task automatic exp_done(input logic n, input logic [7:0] r);
    done_t e;
    e.nack  = n;
    e.rdata = r;
    done_q.push_back(e);
  endtask

  // Pops an expected command on every m_wr and an expected result on every done.
  task automatic monitor();
    logic  prev_wr;
    logic  prev_ready;
    cmd_t  e;
    done_t de;
    prev_wr    = 1'b0;
    prev_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_wr    = 1'b0;
        prev_ready = 1'b1;
      end else begin
        if (bus.m_wr === 1'b1) begin
          wr_cnt++;
          chk("m_wr_after_ready", 32'(prev_ready), 32'd1);
          chk("m_wr_single_cycle", 32'(prev_wr), 32'd0);
          if (cmd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_m_wr: got cmd 0x%0h, expected no command", bus.m_cmd);
          end else begin
            e = cmd_q.pop_front();
            chk("m_cmd", 32'(bus.m_cmd), 32'(e.cmd));
            if (e.cmd == C_WR || e.cmd == C_RD)
              chk("m_din", 32'(bus.m_din), 32'(e.din));
          end
        end
        if (done === 1'b1) begin
          chk("busy_with_done", 32'(busy), 32'd1);
          if (done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1, expected no done");
          end else begin
            de = done_q.pop_front();
            chk("nack_err_at_done", 32'(nack_err), 32'(de.nack));
            chk("rdata_at_done", 32'(rdata), 32'(de.rdata));
          end
        end
        prev_wr    = bus.m_wr;
        prev_ready = bus.m_ready;
      end
    end
  endtask

  // Behavioural byte engine: drops m_ready after each command for lat cycles,
  // then pulses m_done_tick for byte commands.
  task automatic slave_model();
    logic [2:0] c;
    logic [7:0] d;
    int         seen;
    seen            = 0;
    bus.m_ready     = 1'b1;
    bus.m_done_tick = 1'b0;
    bus.m_ack       = 1'b0;
    bus.m_dout      = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && bus.m_wr === 1'b1) begin
        c           = bus.m_cmd;
        d           = bus.m_din;
        bus.m_ready = 1'b0;
        repeat (lat) @(posedge clk);
        #1;
        if (c == C_WR || c == C_RD) begin
          bus.m_ack       = (c == C_WR) && nack_en && (d == nack_din);
          bus.m_dout      = slave_data;
          bus.m_done_tick = 1'b1;
        end
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.m_done_tick = 1'b0;
        bus.m_ack       = 1'b0;
      end else if (spur_cnt != seen) begin
        seen            = spur_cnt;
        bus.m_done_tick = 1'b1;
        bus.m_ack       = 1'b1;
        bus.m_dout      = 8'h00;
        @(posedge clk);
        #1;
        bus.m_done_tick = 1'b0;
        bus.m_ack       = 1'b0;
      end
    end
  endtask

  task automatic issue(input logic r, input logic [6:0] da, input logic [7:0] ra, input logic [7:0] wd);
    @(posedge clk);
    #1;
    rw       = r;
    dev_addr = da;
    reg_addr = ra;
    wdata    = wd;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Returns at the falling edge where done is seen.
  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected done", budget);
    end
  endtask

  task automatic finish_txn();
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("cmds_all_issued", 32'(cmd_q.size()), 32'd0);
    chk("done_all_seen", 32'(done_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_m_wr", 32'(bus.m_wr), 32'd0);
    chk("rst_m_cmd", 32'(bus.m_cmd), 32'd0);
    chk("rst_m_din", 32'(bus.m_din), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_nack_err", 32'(nack_err), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int n;
    rst_n      = 1'b0;
    start      = 1'b0;
    rw         = 1'b0;
    dev_addr   = 7'd0;
    reg_addr   = 8'd0;
    wdata      = 8'd0;
    lat        = 3;
    nack_en    = 1'b0;
    nack_din   = 8'h00;
    slave_data = 8'h00;
    spur_cnt   = 0;
    checks     = 0;
    errors     = 0;
    wr_cnt     = 0;

    fork
      monitor();
      slave_model();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Register write, all ACK.
    exp_cmd(C_START, 8'h00); exp_cmd(C_WR, 8'hA0); exp_cmd(C_WR, 8'h10);
    exp_cmd(C_WR, 8'hA5);    exp_cmd(C_STOP, 8'h00);
    exp_done(1'b0, 8'h00);
    issue(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_done(500);
    finish_txn();

    // Register read, slave returns 0x3C.
    slave_data = 8'h3C;
    exp_cmd(C_START, 8'h00); exp_cmd(C_WR, 8'hA0);   exp_cmd(C_WR, 8'h22);
    exp_cmd(C_RESTART, 8'h00); exp_cmd(C_WR, 8'hA1); exp_cmd(C_RD, 8'h01);
    exp_cmd(C_STOP, 8'h00);
    exp_done(1'b0, 8'h3C);
    issue(1'b1, 7'h50, 8'h22, 8'h00);
    wait_done(500);
    finish_txn();

    // Address NACK on a read: straight to STOP, rdata keeps 0x3C.
    nack_en    = 1'b1;
    nack_din   = 8'hA0;
    slave_data = 8'hEE;
    exp_cmd(C_START, 8'h00); exp_cmd(C_WR, 8'hA0); exp_cmd(C_STOP, 8'h00);
    exp_done(1'b1, 8'h3C);
    issue(1'b1, 7'h50, 8'h33, 8'h00);
    wait_done(500);
    finish_txn();
    nack_en = 1'b0;

    // Slow engine: m_ready low 50 cycles after each command.
    lat = 50;
    exp_cmd(C_START, 8'h00); exp_cmd(C_WR, 8'h54); exp_cmd(C_WR, 8'h05);
    exp_cmd(C_WR, 8'h5A);    exp_cmd(C_STOP, 8'h00);
    exp_done(1'b0, 8'h3C);
    issue(1'b0, 7'h2A, 8'h05, 8'h5A);
    wait_done(2000);
    finish_txn();
    lat = 3;

    // start pulses while busy and in the FINISH cycle are ignored.
    slave_data = 8'h96;
    exp_cmd(C_START, 8'h00);   exp_cmd(C_WR, 8'h22); exp_cmd(C_WR, 8'h80);
    exp_cmd(C_RESTART, 8'h00); exp_cmd(C_WR, 8'h23); exp_cmd(C_RD, 8'h01);
    exp_cmd(C_STOP, 8'h00);
    exp_done(1'b0, 8'h96);
    issue(1'b1, 7'h11, 8'h80, 8'h00);
    repeat (3) begin
      repeat (7) @(posedge clk);
      #1;
      chk("busy_during_txn", 32'(busy), 32'd1);
      rw       = 1'b0;
      dev_addr = 7'h7F;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    wait_done(500);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_txn();

    // Spurious done tick (with NACK) while idle.
    spur_cnt++;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_rdata", 32'(rdata), 32'h96);
    chk("idle_nack_err", 32'(nack_err), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_no_cmds", 32'(cmd_q.size()), 32'd0);

    // Reset during step 3 (RESTART) of a read.
    slave_data = 8'h3C;
    exp_cmd(C_START, 8'h00);   exp_cmd(C_WR, 8'hA0); exp_cmd(C_WR, 8'h22);
    exp_cmd(C_RESTART, 8'h00); exp_cmd(C_WR, 8'hA1); exp_cmd(C_RD, 8'h01);
    exp_cmd(C_STOP, 8'h00);
    exp_done(1'b0, 8'h3C);
    base = wr_cnt;
    issue(1'b1, 7'h50, 8'h22, 8'h00);
    n = 0;
    while (wr_cnt < base + 4 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("reached_restart", 32'(wr_cnt - base), 32'd4);
    #1;
    rst_n = 1'b0;
    cmd_q.delete();
    done_q.delete();
    #1;
    chk_reset_outputs();
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Write after the aborted read; rdata was cleared by reset.
    exp_cmd(C_START, 8'h00); exp_cmd(C_WR, 8'hA0); exp_cmd(C_WR, 8'h10);
    exp_cmd(C_WR, 8'hA5);    exp_cmd(C_STOP, 8'h00);
    exp_done(1'b0, 8'h00);
    issue(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_done(500);
    finish_txn();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
